// File: rtl/wallace_pkg.sv
// ---------------------------------------------------------------------------
// wallace_pkg
// Shared sizing helpers for the parametrised Wallace-tree multiplier.
//   rows_next(rows)        : row count after one 3:2 carry-save level
//   rows_at(rows, level)   : row count entering reduction level 'level'
//   wallace_levels(rows)   : number of reduction levels needed to reach 2 rows
//   latency(width)         : accept-to-out_valid latency in cycles
// ---------------------------------------------------------------------------
package wallace_pkg;

    localparam int WIDTH_MIN = 32'sd4;
    localparam int WIDTH_MAX = 32'sd64;

    // Every full group of three rows becomes a sum row plus a carry row.
    function automatic int rows_next(input int rows);
        return (32'sd2 * (rows / 32'sd3)) + (rows % 32'sd3);
    endfunction

    function automatic int rows_at(input int rows, input int level);
        int r;
        r = rows;
        for (int k = 0; k < WIDTH_MAX; k++) begin
            if (k < level) begin
                r = rows_next(r);
            end
        end
        return r;
    endfunction

    function automatic int wallace_levels(input int rows);
        int r;
        int n;
        r = rows;
        n = 32'sd0;
        for (int k = 0; k < WIDTH_MAX; k++) begin
            if (r > 32'sd2) begin
                r = rows_next(r);
                n = n + 32'sd1;
            end
        end
        return n;
    endfunction

    // Operand register + reduction levels + final adder register.
    function automatic int latency(input int width);
        return wallace_levels(width) + 32'sd2;
    endfunction

endpackage

// File: rtl/csa_level.sv
// ---------------------------------------------------------------------------
// csa_level
// One registered Wallace reduction level. Every full group of three rows is
// compressed 3:2 into a sum row and a carry row; the 1 or 2 leftover rows are
// passed through. Output rows are registered and frozen while en_i is low.
//   clk, rst  : clock, synchronous active-high reset (clears valid only)
//   en_i      : pipe advance enable (low = hold data and valid)
//   valid_i   : incoming rows carry a real operation
//   rows_i    : ROWS_IN flattened rows, W bits each (row k at [k*W +: W])
//   valid_o   : registered valid
//   rows_o    : ROWS_OUT flattened registered rows
// ---------------------------------------------------------------------------
module csa_level
    import wallace_pkg::*;
#(
    parameter int ROWS_IN = 3,
    parameter int W       = 16,
    localparam int ROWS_OUT = rows_next(ROWS_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [ROWS_IN*W-1:0]  rows_i,
    output logic                  valid_o,
    output logic [ROWS_OUT*W-1:0] rows_o
);

    localparam int GROUPS = ROWS_IN / 3;
    localparam int LEFT   = ROWS_IN % 3;

    logic [ROWS_OUT*W-1:0] rows_d;
    logic [ROWS_OUT*W-1:0] rows_q;
    logic                  valid_q;

    // Majority of three bits per column, weighted one column higher.
    function automatic logic [W-1:0] carry3(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] z);
        logic [W-1:0] m;
        m = (x & y) | (x & z) | (y & z);
        return {m[W-2:0], 1'b0};
    endfunction

    // Compress each triple into (sum, carry); leftovers follow the compressed pairs.
    always_comb begin
        rows_d = '0;
        for (int g = 0; g < GROUPS; g++) begin
            rows_d[(2*g)*W +: W]   = rows_i[(3*g)*W +: W] ^ rows_i[(3*g+1)*W +: W]
                                   ^ rows_i[(3*g+2)*W +: W];
            rows_d[(2*g+1)*W +: W] = carry3(rows_i[(3*g)*W +: W], rows_i[(3*g+1)*W +: W],
                                            rows_i[(3*g+2)*W +: W]);
        end
        for (int k = 0; k < LEFT; k++) begin
            rows_d[(2*GROUPS+k)*W +: W] = rows_i[(3*GROUPS+k)*W +: W];
        end
    end

    // Level register; bubbles may carry stale data, only valid is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            rows_q  <= rows_d;
        end
    end

    assign valid_o = valid_q;
    assign rows_o  = rows_q;

endmodule

// File: rtl/param_wallace_multiplier.sv
// ---------------------------------------------------------------------------
// param_wallace_multiplier
// Fully pipelined WIDTH x WIDTH Wallace-tree multiplier with per-operation
// signed/unsigned mode and a valid/ready handshake. Backpressure freezes the
// whole pipe. Latency is wallace_levels(WIDTH) + 2 cycles when not stalled.
//   clk, rst     : clock, synchronous active-high reset
//   a, b         : operands (WIDTH bits)
//   signed_mode  : 1 = two's complement, 0 = unsigned; sampled with a/b
//   in_valid     : operands present
//   in_ready     : pipe can accept (combinational, low only while stalled)
//   product      : 2*WIDTH result of the oldest completed operation
//   out_valid    : product is valid
//   out_ready    : consumer takes product this cycle
// ---------------------------------------------------------------------------
module param_wallace_multiplier
    import wallace_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = 2 * WIDTH;
    localparam int L  = wallace_levels(WIDTH);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
        $error("param_wallace_multiplier: WIDTH out of range");
    end

    logic             stall_s;
    logic             adv_s;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic             v0_q;
    logic [WIDTH*PW-1:0] pp_s;
    logic [PW-1:0]    product_d;
    logic [PW-1:0]    product_q;
    logic             out_valid_q;

    assign stall_s  = out_valid_q & ~out_ready;
    assign adv_s    = ~stall_s;
    assign in_ready = adv_s;

    // Operand stage; mode travels with its operands so modes may mix in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
        end else if (adv_s) begin
            v0_q   <= in_valid;
            a_q    <= a;
            b_q    <= b;
            mode_q <= signed_mode;
        end
    end

    // Partial-product rows. Signed mode inverts terms where exactly one index is
    // the sign bit; the two correction ones sit in row 0's unused bits WIDTH and PW-1.
    always_comb begin
        pp_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_s[i*PW + i + j] = (a_q[j] & b_q[i])
                                   ^ (mode_q & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        pp_s[WIDTH]  = mode_q;
        pp_s[PW - 1] = mode_q;
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int RIN  = rows_at(WIDTH, k);
        localparam int ROUT = rows_next(RIN);

        logic [RIN*PW-1:0]  rows_in_s;
        logic               valid_in_s;
        logic [ROUT*PW-1:0] rows_out_s;
        logic               valid_out_s;

        if (k == 0) begin : g_first
            assign rows_in_s  = pp_s;
            assign valid_in_s = v0_q;
        end else begin : g_next
            assign rows_in_s  = g_lvl[k-1].rows_out_s;
            assign valid_in_s = g_lvl[k-1].valid_out_s;
        end

        csa_level #(
            .ROWS_IN (RIN),
            .W       (PW)
        ) u_csa (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv_s),
            .valid_i (valid_in_s),
            .rows_i  (rows_in_s),
            .valid_o (valid_out_s),
            .rows_o  (rows_out_s)
        );
    end

    // Carry-propagate add; the carry out of the top bit is dropped on purpose.
    assign product_d = g_lvl[L-1].rows_out_s[PW-1:0] + g_lvl[L-1].rows_out_s[2*PW-1:PW];

    // Result register; only a valid operation overwrites product, so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (adv_s) begin
            out_valid_q <= g_lvl[L-1].valid_out_s;
            if (g_lvl[L-1].valid_out_s) begin
                product_q <= product_d;
            end
        end
    end

    assign product   = product_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_param_wallace_multiplier.sv
// ---------------------------------------------------------------------------
// tb_param_wallace_multiplier
// Two instances run side by side: WIDTH=32 for directed and random traffic,
// WIDTH=8 for the exhaustive signed sweep under random out_ready throttling.
// Accepted operations push their expected product into a per-instance queue;
// a monitor pops and compares whenever a result is handed over, and also
// checks the stall-adjusted accept-to-output latency.
// ---------------------------------------------------------------------------
module tb_param_wallace_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=32 instance
    logic        rst32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        m32;
    logic        in_valid32;
    logic        in_ready32;
    logic [63:0] product32;
    logic        out_valid32;
    logic        out_ready32 = 1'b1;
    logic [63:0] exp32;

    // WIDTH=8 instance
    logic        rst8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        m8;
    logic        in_valid8;
    logic        in_ready8;
    logic [15:0] product8;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [15:0] exp8;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] exp;
        int          acc_cyc;
        int          acc_stall;
    } sb_t;

    sb_t q32[$];
    sb_t q8[$];

    param_wallace_multiplier #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst32), .a(a32), .b(b32), .signed_mode(m32),
        .in_valid(in_valid32), .in_ready(in_ready32), .product(product32),
        .out_valid(out_valid32), .out_ready(out_ready32)
    );

    param_wallace_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .signed_mode(m8),
        .in_valid(in_valid8), .in_ready(in_ready8), .product(product8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer multiplication of the operand values.
    function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return 16'(p);
    endfunction

    // ---------------- monitors ----------------
    int cyc32 = 0;
    int stall32 = 0;
    bit head32 = 1'b0;

    always @(negedge clk) begin
        if (rst32) begin
            q32.delete();
            head32 = 1'b0;
        end else begin
            if (out_valid32) begin
                if (q32.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL w32_unexpected: output 0x%0h with nothing outstanding", product32);
                end else begin
                    if (!head32) begin
                        chk("w32_latency", 64'(cyc32 - q32[0].acc_cyc - (stall32 - q32[0].acc_stall)), 64'd10);
                        head32 = 1'b1;
                    end
                    if (out_ready32) begin
                        chk("w32_product", product32, q32[0].exp);
                        void'(q32.pop_front());
                        head32 = 1'b0;
                    end else begin
                        stall32++;
                    end
                end
            end
            if (in_valid32 && in_ready32) q32.push_back('{exp32, cyc32, stall32});
        end
        cyc32++;
    end

    int cyc8 = 0;
    int stall8 = 0;
    bit head8 = 1'b0;

    always @(negedge clk) begin
        if (rst8) begin
            q8.delete();
            head8 = 1'b0;
        end else begin
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL w8_unexpected: output 0x%0h with nothing outstanding", product8);
                end else begin
                    if (!head8) begin
                        chk("w8_latency", 64'(cyc8 - q8[0].acc_cyc - (stall8 - q8[0].acc_stall)), 64'd6);
                        head8 = 1'b1;
                    end
                    if (out_ready8) begin
                        chk("w8_product", {48'd0, product8}, q8[0].exp);
                        void'(q8.pop_front());
                        head8 = 1'b0;
                    end else begin
                        stall8++;
                    end
                end
            end
            if (in_valid8 && in_ready8) q8.push_back('{{48'd0, exp8}, cyc8, stall8});
        end
        cyc8++;
    end

    // ---------------- out_ready throttles ----------------
    bit   rdy_mode32  = 1'b0;
    logic rdy_force32 = 1'b1;

    always @(posedge clk) begin
        #2;
        out_ready32 = rdy_mode32 ? ($urandom_range(0, 3) != 0) : rdy_force32;
    end

    always @(posedge clk) begin
        #2;
        out_ready8 = ($urandom_range(0, 31) != 0);
    end

    // ---------------- WIDTH=8 exhaustive signed sweep ----------------
    bit done8 = 1'b0;

    initial begin
        int   t;
        logic acc;
        rst8 = 1'b1; in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; m8 = 1'b1; exp8 = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b0;
        @(negedge clk);
        chk("w8_reset_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("w8_reset_product", {48'd0, product8}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 65536; i++) begin
            a8 = 8'(i >> 8);
            b8 = 8'(i);
            exp8 = model8(a8, b8);
            in_valid8 = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = in_ready8;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                n_vec++;
                n_err++;
                $display("FAIL w8_accept_timeout: op %0d never accepted", i);
                break;
            end
        end
        in_valid8 = 1'b0;
        done8 = 1'b1;
    end

    // ---------------- WIDTH=32 sequence ----------------
    task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [63:0] e);
        int   t;
        logic acc;
        a32 = x; b32 = y; m32 = s; exp32 = e; in_valid32 = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL w32_accept_timeout: operands 0x%0h 0x%0h never accepted", x, y);
        end
        in_valid32 = 1'b0;
    endtask

    task automatic drain32();
        int t;
        t = 0;
        while ((q32.size() != 0 || out_valid32) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q32.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL w32_drain_timeout: got %0d results outstanding, expected 0", q32.size());
        end
    endtask

    initial begin
        int          t;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rm;
        rst32 = 1'b1; in_valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0; m32 = 1'b0; exp32 = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst32 = 1'b0;
        @(negedge clk);
        chk("w32_reset_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("w32_reset_in_ready", {63'd0, in_ready32}, 64'd1);
        chk("w32_reset_product", product32, 64'd0);
        @(posedge clk);
        #1;

        // Single unsigned operation, exact 10-cycle latency.
        send32(32'hAAAAAAAA, 32'h55555555, 1'b0, 64'h38E38E3871C71C72);
        drain32();

        // Back-to-back with mixed modes.
        send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001);
        send32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
        drain32();

        // Backpressure: freeze with the first result on the output for 4 cycles.
        send32(32'h100, 32'h100, 1'b0, 64'h10000);
        send32(32'd3, 32'd5, 1'b0, 64'd15);
        t = 0;
        while (!out_valid32 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_out_valid_rise", {63'd0, out_valid32}, 64'd1);
        rdy_force32 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_product_hold", product32, 64'h10000);
            chk("bp_in_ready_low", {63'd0, in_ready32}, 64'd0);
            chk("bp_out_valid_hold", {63'd0, out_valid32}, 64'd1);
        end
        @(posedge clk);
        #1 rdy_force32 = 1'b1;
        drain32();

        // Reset mid-flight: ops 0..2 discarded, op 3 lands on the reset cycle, op 4 survives.
        for (int i = 0; i < 5; i++) begin
            a32 = 32'(i + 2);
            b32 = 32'(i + 7);
            m32 = 1'b0;
            exp32 = model32(a32, b32, 1'b0);
            in_valid32 = 1'b1;
            rst32 = (i == 3);
            @(posedge clk);
            #1;
        end
        in_valid32 = 1'b0;
        rst32 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("rst_out_valid_low", {63'd0, out_valid32}, 64'd0);
            chk("rst_product_zero", product32, 64'd0);
        end
        drain32();

        // Random operands and modes with input gaps and output throttling.
        rdy_mode32 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            ra = $urandom;
            rb = $urandom;
            rm = 1'($urandom_range(0, 1));
            send32(ra, rb, rm, model32(ra, rb, rm));
        end
        @(posedge clk);
        #1;
        rdy_mode32 = 1'b0;
        rdy_force32 = 1'b1;
        drain32();

        // Wait for the WIDTH=8 sweep to finish and empty its scoreboard.
        t = 0;
        while (!(done8 && q8.size() == 0) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        if (!(done8 && q8.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL w8_sweep_timeout: got %0d results outstanding, expected 0", q8.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
